mmu_trans_stage: RTL and testbench

Single-port address-translation stage sitting directly downstream of the DMW direct-mapped-window match logic and the TLB lookup.
- Accepts a virtual-address request with a valid/ready handshake.
- Combines CRMD mode, the DMW hit/paddr/mat result and the TLB entry fields into a final physical address, memory type and exception code.
- Buffers the result in a 2-entry output queue for the cache/LSU.
- One instance serves fetch (s0) and one serves load/store (s1).

---
 rtl/mmu_trans_stage.sv | 152 +++++++++++++++
 tb/tb_mmu_trans_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_trans_stage.sv
// mmu_trans_stage: final VA->PA translation (DA / DMW / TLB) with exception
// prioritisation, buffered in a small in-order output queue for the cache/LSU.
module mmu_trans_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic [1:0]  req_plv,
  input  logic [1:0]  req_type,
  input  logic        crmd_da,
  input  logic        crmd_pg,
  input  logic [1:0]  crmd_datf,
  input  logic [1:0]  crmd_datm,
  input  logic        dmw_hit,
  input  logic [31:0] dmw_paddr,
  input  logic [1:0]  dmw_mat,
  input  logic        tlb_found,
  input  logic [19:0] tlb_ppn,
  input  logic [5:0]  tlb_ps,
  input  logic        tlb_v,
  input  logic        tlb_d,
  input  logic [1:0]  tlb_plv,
  input  logic [1:0]  tlb_mat,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic [31:0] resp_vaddr,
  output logic [1:0]  resp_mat,
  output logic [2:0]  resp_exc
);

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_TLBR = 3'd1,
    EXC_PIF  = 3'd2,
    EXC_PIL  = 3'd3,
    EXC_PIS  = 3'd4,
    EXC_PME  = 3'd5,
    EXC_PPI  = 3'd6,
    EXC_ADE  = 3'd7
  } exc_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] vaddr;
    logic [1:0]  mat;
    exc_e        exc;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t       mem_q [DEPTH];
  entry_t       mem_d [DEPTH];
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  entry_t       tr_entry;
  logic         push, pop;

  // Combinational translation of the incoming request into a queue entry
  always_comb begin
    logic        is_fetch;
    logic        is_store;
    logic        da_mode;
    logic [31:0] raw_paddr;
    logic [1:0]  raw_mat;
    exc_e        exc;

    is_fetch  = (req_type == 2'd0);
    is_store  = (req_type == 2'd2);
    // Both CRMD mode bits clear falls back to direct addressing
    da_mode   = crmd_da || !crmd_pg;
    raw_paddr = req_vaddr;
    raw_mat   = crmd_datm;
    exc       = EXC_NONE;

    if (da_mode) begin
      raw_mat = is_fetch ? crmd_datf : crmd_datm;
    end else if (dmw_hit) begin
      raw_paddr = dmw_paddr;
      raw_mat   = dmw_mat;
    end else begin
      // Only 2 MB pages get the wide offset; every other ps is a 4 KB page
      if (tlb_ps == 6'd21) raw_paddr = {tlb_ppn[19:9], req_vaddr[20:0]};
      else                 raw_paddr = {tlb_ppn, req_vaddr[11:0]};
      raw_mat = tlb_mat;
      if (!tlb_found)                exc = EXC_TLBR;
      else if (!tlb_v)               exc = is_fetch ? EXC_PIF : (is_store ? EXC_PIS : EXC_PIL);
      else if (req_plv > tlb_plv)    exc = EXC_PPI;
      else if (is_store && !tlb_d)   exc = EXC_PME;
    end

    // Misaligned fetch outranks every translation fault, in any mode
    if (is_fetch && (req_vaddr[1:0] != 2'b00)) exc = EXC_ADE;

    tr_entry.vaddr = req_vaddr;
    tr_entry.exc   = exc;
    tr_entry.paddr = (exc == EXC_NONE) ? raw_paddr : '0;
    tr_entry.mat   = (exc == EXC_NONE) ? raw_mat   : '0;
  end

  assign req_ready  = (count_q != FULL);
  assign resp_valid = (count_q != 2'd0);
  assign push       = req_valid && req_ready && !flush;
  assign pop        = resp_valid && resp_ready && !flush;

  // Queue bookkeeping: pointer/count advance, storage write, flush clears state
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = tr_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers; reset also zeroes storage so resp_* read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign resp_paddr = mem_q[rd_ptr_q].paddr;
  assign resp_vaddr = mem_q[rd_ptr_q].vaddr;
  assign resp_mat   = mem_q[rd_ptr_q].mat;
  assign resp_exc   = mem_q[rd_ptr_q].exc;

endmodule

// File: tb/tb_mmu_trans_stage.sv
// Directed self-checking bench for mmu_trans_stage.
module tb_mmu_trans_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_plv;
  logic [1:0]  req_type;
  logic        crmd_da;
  logic        crmd_pg;
  logic [1:0]  crmd_datf;
  logic [1:0]  crmd_datm;
  logic        dmw_hit;
  logic [31:0] dmw_paddr;
  logic [1:0]  dmw_mat;
  logic        tlb_found;
  logic [19:0] tlb_ppn;
  logic [5:0]  tlb_ps;
  logic        tlb_v;
  logic        tlb_d;
  logic [1:0]  tlb_plv;
  logic [1:0]  tlb_mat;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic [31:0] resp_vaddr;
  logic [1:0]  resp_mat;
  logic [2:0]  resp_exc;

  int unsigned n_checks;
  int unsigned n_errors;

  mmu_trans_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_plv(req_plv), .req_type(req_type),
    .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_datf(crmd_datf), .crmd_datm(crmd_datm),
    .dmw_hit(dmw_hit), .dmw_paddr(dmw_paddr), .dmw_mat(dmw_mat),
    .tlb_found(tlb_found), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps), .tlb_v(tlb_v),
    .tlb_d(tlb_d), .tlb_plv(tlb_plv), .tlb_mat(tlb_mat),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_vaddr(resp_vaddr), .resp_mat(resp_mat), .resp_exc(resp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; req_valid = 0; req_vaddr = '0; req_plv = '0; req_type = '0;
    crmd_da = 1; crmd_pg = 0; crmd_datf = '0; crmd_datm = '0;
    dmw_hit = 0; dmw_paddr = '0; dmw_mat = '0;
    tlb_found = 0; tlb_ppn = '0; tlb_ps = '0; tlb_v = 0; tlb_d = 0; tlb_plv = '0; tlb_mat = '0;
  endtask

  task automatic pg_tlb(input logic found, input logic [19:0] ppn, input logic [5:0] ps,
                        input logic v, input logic d, input logic [1:0] plv, input logic [1:0] mat);
    crmd_da = 0; crmd_pg = 1; dmw_hit = 0;
    tlb_found = found; tlb_ppn = ppn; tlb_ps = ps; tlb_v = v; tlb_d = d; tlb_plv = plv; tlb_mat = mat;
  endtask

  // one-cycle request, then check the result the following cycle
  task automatic xlate(input string tag, input logic [31:0] va, input logic [1:0] typ,
                       input logic [1:0] plv, input logic [31:0] exp_pa,
                       input logic [1:0] exp_mat, input logic [2:0] exp_exc);
    req_valid = 1; req_vaddr = va; req_type = typ; req_plv = plv;
    tick();
    req_valid = 0;
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_paddr"}, 64'(resp_paddr), 64'(exp_pa));
    chk({tag, "_vaddr"}, 64'(resp_vaddr), 64'(va));
    chk({tag, "_mat"},   64'(resp_mat),   64'(exp_mat));
    chk({tag, "_exc"},   64'(resp_exc),   64'(exp_exc));
    tick();  // consumer pops the result
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    resp_ready = 1;
    rst = 1;
    tick();
    tick();
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_paddr", 64'(resp_paddr), 64'd0);
    chk("rst_vaddr", 64'(resp_vaddr), 64'd0);
    chk("rst_exc",   64'(resp_exc),   64'd0);
    rst = 0;
    tick();

    // DA mode
    crmd_da = 1; crmd_pg = 0; crmd_datf = 2'd1; crmd_datm = 2'd2;
    xlate("da_fetch", 32'h1C00_0000, 2'd0, 2'd0, 32'h1C00_0000, 2'd1, 3'd0);
    xlate("da_load",  32'h0000_4004, 2'd1, 2'd0, 32'h0000_4004, 2'd2, 3'd0);
    crmd_da = 0; crmd_pg = 0;
    xlate("da_both0", 32'h0000_5000, 2'd2, 2'd3, 32'h0000_5000, 2'd2, 3'd0);
    crmd_da = 1; crmd_pg = 1;
    xlate("da_ade",   32'h0000_0001, 2'd0, 2'd0, 32'h0, 2'd0, 3'd7);

    // PG with DMW hit: no TLB checks
    crmd_da = 0; crmd_pg = 1; dmw_hit = 1; dmw_paddr = 32'h0000_1234; dmw_mat = 2'd1; tlb_found = 0;
    xlate("dmw", 32'h9000_1234, 2'd1, 2'd3, 32'h0000_1234, 2'd1, 3'd0);

    // PG through TLB: {ppn[19:9], va[20:0]} = {11'h002, 21'h123456}
    pg_tlb(1, 20'h00400, 6'd21, 1, 1, 2'd0, 2'd2);
    xlate("tlb_2m", 32'h0012_3456, 2'd1, 2'd0, 32'h0052_3456, 2'd2, 3'd0);
    pg_tlb(1, 20'h12345, 6'd12, 1, 1, 2'd3, 2'd1);
    xlate("tlb_4k", 32'hFFFF_FABC, 2'd2, 2'd1, 32'h1234_5ABC, 2'd1, 3'd0);
    pg_tlb(1, 20'h12345, 6'd0, 1, 1, 2'd3, 2'd1);
    xlate("tlb_ps0", 32'h0000_0ABC, 2'd1, 2'd0, 32'h1234_5ABC, 2'd1, 3'd0);
    pg_tlb(1, 20'h00400, 6'd21, 0, 1, 2'd0, 2'd2);
    xlate("pil", 32'h0012_3456, 2'd1, 2'd0, 32'h0, 2'd0, 3'd3);
    xlate("pif", 32'h0012_3454, 2'd0, 2'd0, 32'h0, 2'd0, 3'd2);
    xlate("pis", 32'h0012_3456, 2'd2, 2'd0, 32'h0, 2'd0, 3'd4);
    xlate("pil_rsv", 32'h0012_3456, 2'd3, 2'd0, 32'h0, 2'd0, 3'd3);
    pg_tlb(1, 20'h00400, 6'd21, 1, 0, 2'd0, 2'd2);
    xlate("pme", 32'h0012_3456, 2'd2, 2'd0, 32'h0, 2'd0, 3'd5);
    xlate("ppi_st", 32'h0012_3456, 2'd2, 2'd3, 32'h0, 2'd0, 3'd6);
    xlate("ppi_ld", 32'h0012_3456, 2'd1, 2'd3, 32'h0, 2'd0, 3'd6);
    xlate("plv_eq", 32'h0012_3456, 2'd1, 2'd0, 32'h0052_3456, 2'd2, 3'd0);
    pg_tlb(0, 20'h00400, 6'd21, 1, 1, 2'd0, 2'd2);
    xlate("tlbr", 32'h0012_3456, 2'd1, 2'd0, 32'h0, 2'd0, 3'd1);
    xlate("ade_tlbr", 32'h8000_0002, 2'd0, 2'd0, 32'h0, 2'd0, 3'd7);

    // Backpressure: A, B accepted, C held until space frees
    idle_inputs();
    crmd_datm = 2'd1;
    resp_ready = 0;
    req_valid = 1; req_type = 2'd1; req_vaddr = 32'h0000_0A00;
    tick();
    chk("bp_ready1", 64'(req_ready), 64'd1);
    req_vaddr = 32'h0000_0B00;
    tick();
    chk("bp_full", 64'(req_ready), 64'd0);
    chk("bp_headA", 64'(resp_vaddr), 64'h0A00);
    req_vaddr = 32'h0000_0C00;
    tick();
    chk("bp_hold_ready", 64'(req_ready), 64'd0);
    chk("bp_hold_head", 64'(resp_vaddr), 64'h0A00);
    chk("bp_hold_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1;
    tick();
    chk("bp_headB", 64'(resp_vaddr), 64'h0B00);
    chk("bp_ready2", 64'(req_ready), 64'd1);
    tick();
    req_valid = 0;
    chk("bp_headC", 64'(resp_vaddr), 64'h0C00);
    chk("bp_C_valid", 64'(resp_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(resp_valid), 64'd0);

    // Flush with a full queue and a pending request
    resp_ready = 0;
    req_valid = 1; req_vaddr = 32'h0000_0D00;
    tick();
    req_vaddr = 32'h0000_0E00;
    tick();
    chk("fl_full", 64'(req_ready), 64'd0);
    flush = 1; resp_ready = 1; req_vaddr = 32'h0000_0F00;
    chk("fl_ready_during", 64'(req_ready), 64'd0);
    tick();
    flush = 0; req_valid = 0;
    chk("fl_valid", 64'(resp_valid), 64'd0);
    chk("fl_ready", 64'(req_ready), 64'd1);
    tick();
    chk("fl_no_ghost", 64'(resp_valid), 64'd0);
    // Flush with one entry plus an acceptable request
    resp_ready = 0;
    req_valid = 1; req_vaddr = 32'h0000_1100;
    tick();
    flush = 1; req_vaddr = 32'h0000_1200;
    tick();
    flush = 0;
    req_vaddr = 32'h0000_1300;
    chk("fl1_valid", 64'(resp_valid), 64'd0);
    tick();
    req_valid = 0;
    chk("fl_after_head", 64'(resp_vaddr), 64'h1300);
    chk("fl_after_valid", 64'(resp_valid), 64'd1);

    // Reset in the middle of traffic
    req_valid = 1; req_vaddr = 32'h0000_1400;
    tick();
    req_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_valid", 64'(resp_valid), 64'd0);
    chk("mrst_paddr", 64'(resp_paddr), 64'd0);
    chk("mrst_vaddr", 64'(resp_vaddr), 64'd0);
    chk("mrst_mat",   64'(resp_mat),   64'd0);
    chk("mrst_exc",   64'(resp_exc),   64'd0);
    chk("mrst_ready", 64'(req_ready),  64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
